as_macc_seq: RTL
================

# as_macc_seq

Multiply-accumulate sequencer that drives the control and operand inputs of the `as_alu` datapath. It evaluates an affine pixel expression, `result = c0 + c1*x + c2*y`, using the ALU's accumulator (ACC) over consecutive cycles. It sits between a request source (e.g. the pixel address generator) and the ALU, with a valid/ready handshake on both sides. The sequencer does no arithmetic itself; all adds and multiplies happen in `as_alu`.

## Interface
Parameters:
- `n`, default 8: datapath width. Matches the ALU `n`. Coefficients `c1`/`c2` use the ALU's Q1.7 immediate format.

Ports. The design uses one clock; reset is asynchronous and active-high.
- `clk`  in  1  system clock, rising-edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  sequencer can accept a request.
- `req_two_term`  in  1  when 1, compute `c0 + c1*x` only (skip the y term).
- `req_x`, `req_y`  in  n  operand coordinates.
- `req_c0`  in  n  additive constant.
- `req_c1`, `req_c2`  in  n  Q1.7 multipliers.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer takes result.
- `res_data`  out  n  result; combinationally equal to `alu_acc_out`.
- `alu_acc_out`  in  n  ALU ACC output.
- `alu_rd_data`, `alu_rs_data`, `alu_immediate`  out  n  ALU operands.
- `alu_add_a_sel`, `alu_add_b_sel`, `alu_acc_en`, `alu_acc_add`, `alu_in_en`  out  1  ALU controls.
- `job_count`  out  8  completed-job counter. Present only with `AS_SEQ_STATUS_EN`.

## Operation
- States: IDLE, LOAD, MAC_X, MAC_Y, RESULT.
- IDLE:
  - `req_ready=1`.
  - On `req_valid`, capture all `req_*` fields into internal registers and go to LOAD.
- LOAD:
  - Drive `alu_add_b_sel=1`, `alu_acc_en=1`, `alu_rd_data=0`, `alu_immediate=c0`.
  - The ACC loads `c0` at the next edge.
  - Next state: MAC_X.
- MAC_X:
  - Drive `alu_acc_add=1`, `alu_acc_en=1`, `alu_add_b_sel=0`, `alu_rs_data=x`, `alu_immediate=c1`.
  - Next state: RESULT if `two_term`, else MAC_Y.
- MAC_Y:
  - Same controls as MAC_X, with `alu_rs_data=y` and `alu_immediate=c2`.
  - Next state: RESULT.
- RESULT:
  - `res_valid=1`, `alu_acc_en=0`, so the ACC holds its value.
  - Return to IDLE on `res_valid && res_ready`.
- Fixed outputs in every state: `alu_add_a_sel=0`, `alu_in_en=0`, `alu_rd_data=0`.
- Outside the states listed above, all ALU control outputs are 0 and all operand outputs are 0.
- Overflow and truncation follow ALU behaviour. The sequencer neither detects nor saturates.

## Timing
- All ALU control and operand outputs are registered-state decodes, and glitch-free relative to `clk`.
- Latency: a request accepted at edge T0 produces `res_valid=1` after edge T3 (three-term) or after edge T2 (two-term).
- Throughput: one job per 5 cycles (three-term) or 4 cycles (two-term) with `res_ready` held high. This includes the IDLE acceptance cycle.
- `req_ready=0` in every state except IDLE. A request asserted while busy is held off and is not dropped.
- Captured request fields are frozen from acceptance until the return to IDLE. Changes on the `req_*` inputs during that time have no effect.
- Backpressure: in RESULT with `res_ready=0`, `res_valid` and `res_data` stay stable indefinitely.
- Reset, asserted at any time including mid-job:
  - Immediately go to IDLE.
  - `req_ready=1`, `res_valid=0`, all `alu_*` outputs 0, `job_count=0`, captured fields 0.
- The ACC contents after a reset are owned by the ALU's own reset. The sequencer always reloads the ACC in LOAD, so stale ACC data never reaches a result.

## Configuration
- Macro: `AS_SEQ_STATUS_EN`.
- Defined:
  - The `job_count` port exists.
  - It increments by 1 on each `res_valid && res_ready` handshake.
  - It wraps from 255 to 0.
  - It is cleared by reset.
- Undefined:
  - The port and the counter are absent.
  - All other behaviour is identical.

## Test plan
- Three-term job: c0=6, c1=8'h60 (0.75), x=20, c2=8'h20 (0.25), y=40, `res_ready=1`. Expect `res_data=31` with `res_valid` high 4 cycles after acceptance, then `req_ready=1` on the next cycle.
- Two-term job: same values with `req_two_term=1`. Expect `res_data=21` 3 cycles after acceptance; MAC_Y is never entered (`alu_rs_data` is never 40).
- Backpressure: hold `res_ready=0` for 5 cycles in RESULT. Expect `res_valid=1`, `res_data` constant, `req_ready=0` and `alu_acc_en=0` throughout, and IDLE one cycle after `res_ready` rises.
- Input freeze: change `req_x` from 20 to 99 during LOAD. Expect the result to still be 31.
- Reset mid-job: assert `reset` during MAC_X. Expect all `alu_*` outputs 0, `res_valid=0` and `req_ready=1` immediately. A following job with the first test's values yields 31.
- With `AS_SEQ_STATUS_EN` defined: run 256 handshaked jobs. Expect `job_count` to read 255 after job 255 and 0 after job 256.

Source files
------------

// File: rtl/as_macc_seq.sv
// Multiply-accumulate sequencer driving as_alu to evaluate c0 + c1*x + c2*y in the ALU accumulator.
// Optional build macro AS_SEQ_STATUS_EN adds the job_count completed-job counter port.
module as_macc_seq #(
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_two_term,
  input  logic [n-1:0] req_x,
  input  logic [n-1:0] req_y,
  input  logic [n-1:0] req_c0,
  input  logic [n-1:0] req_c1,
  input  logic [n-1:0] req_c2,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [n-1:0] res_data,
  input  logic [n-1:0] alu_acc_out,
  output logic [n-1:0] alu_rd_data,
  output logic [n-1:0] alu_rs_data,
  output logic [n-1:0] alu_immediate,
  output logic         alu_add_a_sel,
  output logic         alu_add_b_sel,
  output logic         alu_acc_en,
  output logic         alu_acc_add,
  output logic         alu_in_en
`ifdef AS_SEQ_STATUS_EN
  ,
  output logic [7:0]   job_count
`endif
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    MAC_X  = 3'd2,
    MAC_Y  = 3'd3,
    RESULT = 3'd4
  } state_t;

  state_t         state_r;
  state_t         state_s;
  logic           accept_s;
  logic           done_s;

  logic           two_term_r;
  logic [n-1:0]   x_r;
  logic [n-1:0]   y_r;
  logic [n-1:0]   c0_r;
  logic [n-1:0]   c1_r;
  logic [n-1:0]   c2_r;

  logic           two_term_s;
  logic [n-1:0]   x_s;
  logic [n-1:0]   y_s;
  logic [n-1:0]   c0_s;
  logic [n-1:0]   c1_s;
  logic [n-1:0]   c2_s;

  logic           req_ready_s;
  logic           res_valid_s;
  logic           add_b_sel_s;
  logic           acc_en_s;
  logic           acc_add_s;
  logic [n-1:0]   rs_data_s;
  logic [n-1:0]   immediate_s;

  logic           req_ready_r;
  logic           res_valid_r;
  logic           add_b_sel_r;
  logic           acc_en_r;
  logic           acc_add_r;
  logic [n-1:0]   rs_data_r;
  logic [n-1:0]   immediate_r;

  assign accept_s = (state_r == IDLE) && req_valid;
  assign done_s   = (state_r == RESULT) && res_ready;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          state_s = LOAD;
        end else begin
          state_s = IDLE;
        end
      end
      LOAD:  state_s = MAC_X;
      MAC_X: begin
        if (two_term_r) begin
          state_s = RESULT;
        end else begin
          state_s = MAC_Y;
        end
      end
      MAC_Y: state_s = RESULT;
      RESULT: begin
        if (res_ready) begin
          state_s = IDLE;
        end else begin
          state_s = RESULT;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Request fields are sampled only on acceptance and frozen until the next one.
  always_comb begin
    if (accept_s) begin
      two_term_s = req_two_term;
      x_s        = req_x;
      y_s        = req_y;
      c0_s       = req_c0;
      c1_s       = req_c1;
      c2_s       = req_c2;
    end else begin
      two_term_s = two_term_r;
      x_s        = x_r;
      y_s        = y_r;
      c0_s       = c0_r;
      c1_s       = c1_r;
      c2_s       = c2_r;
    end
  end

  // Captured request field registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      two_term_r <= 1'b0;
      x_r        <= {n{1'b0}};
      y_r        <= {n{1'b0}};
      c0_r       <= {n{1'b0}};
      c1_r       <= {n{1'b0}};
      c2_r       <= {n{1'b0}};
    end else begin
      two_term_r <= two_term_s;
      x_r        <= x_s;
      y_r        <= y_s;
      c0_r       <= c0_s;
      c1_r       <= c1_s;
      c2_r       <= c2_s;
    end
  end

  // Output decode of the upcoming state, so every ALU control leaves a flop.
  always_comb begin
    req_ready_s = 1'b0;
    res_valid_s = 1'b0;
    add_b_sel_s = 1'b0;
    acc_en_s    = 1'b0;
    acc_add_s   = 1'b0;
    rs_data_s   = {n{1'b0}};
    immediate_s = {n{1'b0}};
    case (state_s)
      IDLE: begin
        req_ready_s = 1'b1;
      end
      LOAD: begin
        add_b_sel_s = 1'b1;
        acc_en_s    = 1'b1;
        immediate_s = c0_s;
      end
      MAC_X: begin
        acc_en_s    = 1'b1;
        acc_add_s   = 1'b1;
        rs_data_s   = x_s;
        immediate_s = c1_s;
      end
      MAC_Y: begin
        acc_en_s    = 1'b1;
        acc_add_s   = 1'b1;
        rs_data_s   = y_s;
        immediate_s = c2_s;
      end
      RESULT: begin
        res_valid_s = 1'b1;
      end
      default: begin
        req_ready_s = 1'b0;
      end
    endcase
  end

  // Output registers; reset leaves the sequencer idle and the ALU quiescent.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_ready_r <= 1'b1;
      res_valid_r <= 1'b0;
      add_b_sel_r <= 1'b0;
      acc_en_r    <= 1'b0;
      acc_add_r   <= 1'b0;
      rs_data_r   <= {n{1'b0}};
      immediate_r <= {n{1'b0}};
    end else begin
      req_ready_r <= req_ready_s;
      res_valid_r <= res_valid_s;
      add_b_sel_r <= add_b_sel_s;
      acc_en_r    <= acc_en_s;
      acc_add_r   <= acc_add_s;
      rs_data_r   <= rs_data_s;
      immediate_r <= immediate_s;
    end
  end

  assign req_ready     = req_ready_r;
  assign res_valid     = res_valid_r;
  assign res_data      = alu_acc_out;
  assign alu_rd_data   = {n{1'b0}};
  assign alu_rs_data   = rs_data_r;
  assign alu_immediate = immediate_r;
  assign alu_add_a_sel = 1'b0;
  assign alu_add_b_sel = add_b_sel_r;
  assign alu_acc_en    = acc_en_r;
  assign alu_acc_add   = acc_add_r;
  assign alu_in_en     = 1'b0;

`ifdef AS_SEQ_STATUS_EN
  logic [7:0] job_count_r;

  // Completed-job counter, wraps modulo 256.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      job_count_r <= 8'd0;
    end else if (done_s) begin
      job_count_r <= job_count_r + 8'd1;
    end else begin
      job_count_r <= job_count_r;
    end
  end

  assign job_count = job_count_r;
`else
  logic unused_done_s;
  assign unused_done_s = done_s;
`endif

endmodule
